// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit: stack/frame pointer registers with push/pop and two-cycle ENTER/LEAVE.
// Define STACK_BOUNDS_CHECK_EN to trap out-of-range push/pop steps with sticky fault flags.
module stack_pointer_unit #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_SP    = WIDTH'(32'h0000_0999),
    parameter logic [WIDTH-1:0]   STACK_LIMIT = WIDTH'(32'h0000_0000),
    parameter int                 WORD_BYTES  = 4
) (
    input  logic             clock_4,
    input  logic             reset,
    input  logic [3:0]       read_or_write,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] stack_addr,
    output logic [WIDTH-1:0] frame_addr,
    output logic             busy,
    output logic             overflow,
    output logic             underflow
);
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif
    localparam logic [WIDTH-1:0] STEP = WIDTH'(WORD_BYTES);

    localparam logic [3:0] CMD_WR_SP = 4'h5;
    localparam logic [3:0] CMD_WR_FP = 4'h6;
    localparam logic [3:0] CMD_PUSH  = 4'h7;
    localparam logic [3:0] CMD_POP   = 4'h8;
    localparam logic [3:0] CMD_ENTER = 4'h9;
    localparam logic [3:0] CMD_LEAVE = 4'hA;
    localparam logic [3:0] CMD_CLR   = 4'hF;

    typedef enum logic [1:0] {IDLE, ENTER2, LEAVE2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sp_q, sp_d, fp_q, fp_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [WIDTH:0]   sp_dec, sp_inc;
    logic             push_bad, pop_bad;

    // Extra top bit catches borrow/carry so wrap is detected alongside the limit compare.
    assign sp_dec   = {1'b0, sp_q} - {1'b0, STEP};
    assign sp_inc   = {1'b0, sp_q} + {1'b0, STEP};
    assign push_bad = CHECK && (sp_dec[WIDTH] || sp_dec[WIDTH-1:0] < STACK_LIMIT);
    assign pop_bad  = CHECK && (sp_inc[WIDTH] || sp_inc[WIDTH-1:0] > RESET_SP);

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        fp_d    = fp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: begin
                case (read_or_write)
                    CMD_WR_SP: sp_d = write_data;
                    CMD_WR_FP: fp_d = write_data;
                    CMD_PUSH, CMD_ENTER: begin
                        if (push_bad) ovf_d = 1'b1;
                        else          sp_d  = sp_dec[WIDTH-1:0];
                        if (read_or_write == CMD_ENTER) state_d = ENTER2;
                    end
                    CMD_POP: begin
                        if (pop_bad) unf_d = 1'b1;
                        else         sp_d  = sp_inc[WIDTH-1:0];
                    end
                    CMD_LEAVE: begin
                        sp_d    = fp_q;
                        state_d = LEAVE2;
                    end
                    CMD_CLR: begin
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            ENTER2: begin
                fp_d    = sp_q;
                state_d = IDLE;
            end
            LEAVE2: begin
                if (pop_bad) unf_d = 1'b1;
                else         sp_d  = sp_inc[WIDTH-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clock_4) begin
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= RESET_SP;
            fp_q    <= RESET_SP;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fp_q    <= fp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign stack_addr = sp_q;
    assign frame_addr = fp_q;
    assign busy       = state_q != IDLE;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
endmodule

// File: doc/stack_pointer_unit.md
# stack_pointer_unit

Parametrised stack/frame pointer unit replacing the single fixed-width stack address register in the CPU datapath. Holds the stack pointer and frame pointer. Executes direct writes, push/pop adjustments and two-cycle ENTER/LEAVE frame sequences decoded from the existing 4-bit `read_or_write` command bus. Optionally traps out-of-range stack movement with sticky fault flags. Sits beside the register file; its outputs feed the memory address mux in the phase-4 stage.

## Interface
- `WIDTH`, 32: pointer width in bits.
- `RESET_SP`, 32'h0000_0999: stack base; reset value of `stack_addr` and `frame_addr`; upper bound for pops.
- `STACK_LIMIT`, 32'h0000_0000: lowest legal stack address.
- `WORD_BYTES`, 4: push/pop step in bytes.

- `clock_4`  in  1  phase-4 clock; all state updates on its falling edge.
- `reset`  in  1  synchronous, active-high; sampled on the falling edge of `clock_4`.
- `read_or_write`  in  4  command: 0x0 NOP, 0x5 write SP, 0x6 write FP, 0x7 PUSH, 0x8 POP, 0x9 ENTER, 0xA LEAVE, 0xF clear faults; other codes act as NOP.
- `write_data`  in  WIDTH  data for 0x5/0x6.
- `stack_addr`  out  WIDTH  current stack pointer (registered).
- `frame_addr`  out  WIDTH  current frame pointer (registered).
- `busy`  out  1  high during the second cycle of ENTER/LEAVE.
- `overflow`  out  1  sticky: a push/enter step would go below `STACK_LIMIT`.
- `underflow`  out  1  sticky: a pop/leave step would go above `RESET_SP`.

## Operation
- Reset: `stack_addr`=`frame_addr`=RESET_SP; `busy`=0; `overflow`=`underflow`=0; FSM to IDLE. Reset overrides any command, including mid-ENTER/LEAVE.
- FSM states: IDLE, ENTER2, LEAVE2.
- IDLE:
  - 0x5: SP ← `write_data`.
  - 0x6: FP ← `write_data`.
  - 0x7: SP ← SP − WORD_BYTES.
  - 0x8: SP ← SP + WORD_BYTES.
  - 0x9: SP ← SP − WORD_BYTES; go to ENTER2.
  - 0xA: SP ← FP; go to LEAVE2.
  - 0xF: both fault flags ← 0.
- ENTER2: FP ← SP (the decremented value); return to IDLE.
- LEAVE2: SP ← SP + WORD_BYTES; return to IDLE.
- Commands presented while `busy`=1 are ignored, 0xF included. The issuer holds NOP during that cycle.
- Arithmetic is unsigned, modulo 2^WIDTH.
- Direct writes (0x5/0x6) are never bounds-checked.
- The two fault flags are independent and sticky. They clear only on reset or 0xF.

## Timing
- Single-cycle commands: result visible on the outputs immediately after the falling edge that sampled the command. Latency 1.
- ENTER/LEAVE: 2 edges. `busy` is high between edge 1 and edge 2. Final SP and FP are valid after edge 2.
- No combinational path from any input to any output.
- A fault and 0xF can never coincide: faults arise only from 0x7/0x8/0x9/LEAVE2, and 0xF is a separate command.

## Configuration
- Macro: `STACK_BOUNDS_CHECK_EN`.
- Defined:
  - A PUSH or ENTER step whose result would be < STACK_LIMIT, or would wrap below zero, leaves SP unchanged and sets `overflow`.
  - A faulting ENTER still completes ENTER2, copying the unchanged SP into FP.
  - A POP or LEAVE2 step whose result would be > RESET_SP, or would wrap, leaves SP unchanged and sets `underflow`.
- Undefined: no checks are made. Arithmetic wraps freely. `overflow` and `underflow` are tied to 0.

## Test plan
- Reset → SP=FP=0x999, `busy`=0, both flags 0. Then 0x5 with `write_data`=0x500 → SP=0x500 after one edge; FP stays 0x999.
- From SP=0x999: PUSH ×3 → SP=0x98D. Then POP → SP=0x991.
- From SP=0x900, FP=0x999: ENTER → after edge 1 SP=0x8FC, `busy`=1. After edge 2 FP=0x8FC, `busy`=0. A PUSH held during the busy cycle has no effect.
- From SP=0x8F0, FP=0x8FC: LEAVE → after edge 1 SP=0x8FC. After edge 2 SP=0x900, FP=0x8FC.
- With `STACK_BOUNDS_CHECK_EN` defined and STACK_LIMIT=0x990, SP=0x991: PUSH → SP=0x991 and `overflow`=1. POP ×2 → 0x995, then 0x999. POP again → SP=0x999 and `underflow`=1. 0xF → both flags 0.
- ENTER, then `reset` asserted on edge 2 → SP=FP=0x999, `busy`=0, FSM in IDLE.
